// File: rtl/movimiento_pkg.sv
// movimiento_pkg: selector codes, sequencer states and direction priority shared with control_movimiento.
package movimiento_pkg;
    localparam logic [2:0] SEL_REPOSO    = 3'b000;
    localparam logic [2:0] SEL_INICIO    = 3'b001;
    localparam logic [2:0] SEL_DERECHA   = 3'b010;
    localparam logic [2:0] SEL_ARRIBA    = 3'b011;
    localparam logic [2:0] SEL_ABAJO     = 3'b100;
    localparam logic [2:0] SEL_IZQUIERDA = 3'b101;
    localparam logic [2:0] SEL_GENERAR   = 3'b111;
    localparam logic [2:0] EST_REPOSO  = 3'd0;
    localparam logic [2:0] EST_INICIO  = 3'd1;
    localparam logic [2:0] EST_MOVER   = 3'd2;
    localparam logic [2:0] EST_GENERAR = 3'd3;
    localparam logic [2:0] EST_SOLTAR  = 3'd4;
    localparam logic [2:0] EST_BLOQUEO = 3'd5;
    function automatic logic [2:0] codigo_direccion(input logic [2:0] arr_aba_izq);
        return arr_aba_izq[2] ? SEL_ARRIBA : arr_aba_izq[1] ? SEL_ABAJO :
               arr_aba_izq[0] ? SEL_IZQUIERDA : SEL_DERECHA;
    endfunction
endpackage

// File: rtl/antirrebote.sv
// antirrebote: 2-flop synchronizer plus debouncer; a level held since reset must be released before its next press counts.
module antirrebote #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic boton,
    output logic nivel,
    output logic flanco
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          armado;
    logic          pend;
    logic          listo;
    assign pend  = (sync[1] != nivel) || (!armado && !sync[1]);
    assign listo = pend && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            cnt    <= '0;
            armado <= 1'b0;
            nivel  <= 1'b0;
            flanco <= 1'b0;
        end else begin
            sync   <= {sync[0], boton};
            cnt    <= (listo || !pend) ? '0 : cnt + CW'(1);
            flanco <= listo && sync[1] && armado;
            if (listo) begin
                nivel  <= sync[1];
                armado <= armado | !sync[1];
            end
        end
    end
endmodule

// File: rtl/secuenciador_movimiento.sv
// secuenciador_movimiento: debounced buttons to timed selector sequences; SECUENCIADOR_CONTADOR_EN adds cuenta_movs.
module secuenciador_movimiento
    import movimiento_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_arriba,
    input  logic       btn_abajo,
    input  logic       btn_izquierda,
    input  logic       btn_derecha,
    input  logic       btn_inicio,
    input  logic       gano,
    input  logic       perdio,
    output logic [2:0] selector,
    output logic       ocupado
`ifdef SECUENCIADOR_CONTADOR_EN
    ,
    output logic [15:0] cuenta_movs
`endif
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    logic [4:0]    crudo;
    logic [4:0]    nivel;
    logic [4:0]    flanco;
    logic [2:0]    state;
    logic [2:0]    nxt;
    logic [2:0]    dir;
    logic [HW-1:0] hold;
    logic          fin;
    logic          fin_juego;
    assign crudo = {btn_inicio, btn_arriba, btn_abajo, btn_izquierda, btn_derecha};
    genvar i;
    for (i = 0; i < 5; i++) begin : g_btn
        antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_antirrebote (
            .clk   (clk),
            .rst_n (rst_n),
            .boton (crudo[i]),
            .nivel (nivel[i]),
            .flanco(flanco[i])
        );
    end
    assign fin       = hold == HW'(HOLD_CYCLES - 1);
    assign fin_juego = gano | perdio;
    assign ocupado   = state == EST_INICIO || state == EST_MOVER || state == EST_GENERAR;
    assign selector  = state == EST_INICIO  ? SEL_INICIO :
                       state == EST_MOVER   ? dir :
                       state == EST_GENERAR ? SEL_GENERAR : SEL_REPOSO;
    always_comb begin
        nxt = state;
        case (state)
            EST_REPOSO:  nxt = flanco[4] ? EST_INICIO : fin_juego ? EST_BLOQUEO :
                               |flanco[3:0] ? EST_MOVER : EST_REPOSO;
            EST_INICIO:  nxt = fin ? EST_SOLTAR : EST_INICIO;
            EST_MOVER:   nxt = fin ? EST_GENERAR : EST_MOVER;
            EST_GENERAR: nxt = fin ? EST_SOLTAR : EST_GENERAR;
            EST_SOLTAR:  nxt = |nivel ? EST_SOLTAR : fin_juego ? EST_BLOQUEO : EST_REPOSO;
            EST_BLOQUEO: nxt = flanco[4] ? EST_INICIO : EST_BLOQUEO;
            default:     nxt = EST_REPOSO;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EST_REPOSO;
            hold  <= '0;
            dir   <= SEL_REPOSO;
        end else begin
            state <= nxt;
            hold  <= (nxt != state || !ocupado) ? '0 : hold + HW'(1);
            if (state == EST_REPOSO && nxt == EST_MOVER)
                dir <= codigo_direccion(flanco[3:1]);
        end
    end
`ifdef SECUENCIADOR_CONTADOR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cuenta_movs <= '0;
        else if (nxt == EST_INICIO && state != EST_INICIO)
            cuenta_movs <= '0;
        else if (state == EST_MOVER && nxt == EST_GENERAR && cuenta_movs != 16'hFFFF)
            cuenta_movs <= cuenta_movs + 16'd1;
    end
`endif
endmodule

// File: tb/tb_secuenciador_movimiento.sv
// tb_secuenciador_movimiento: randomized presses checked by a queue scoreboard fed from a press-level model.
module tb_secuenciador_movimiento;
    localparam int DEB  = 16;
    localparam int HOLD = 4;
    typedef struct {
        logic [2:0] code;
        int         len;
    } seg_t;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       b_ar = 1'b0, b_ab = 1'b0, b_iz = 1'b0, b_de = 1'b0, b_in = 1'b0;
    logic       gano = 1'b0, perdio = 1'b0;
    logic [2:0] selector;
    logic       ocupado;
`ifdef SECUENCIADOR_CONTADOR_EN
    logic [15:0] cuenta_movs;
`endif
    seg_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    bit         mon_en = 0;
    logic [2:0] prev_sel = 3'b000;
    int         run_len = 0;
    bit         bloqueado = 0;
    int         movs = 0;

    secuenciador_movimiento #(.DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_arriba   (b_ar),
        .btn_abajo    (b_ab),
        .btn_izquierda(b_iz),
        .btn_derecha  (b_de),
        .btn_inicio   (b_in),
        .gano         (gano),
        .perdio       (perdio),
        .selector     (selector),
        .ocupado      (ocupado)
`ifdef SECUENCIADOR_CONTADOR_EN
        ,
        .cuenta_movs  (cuenta_movs)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic finish_run(input logic [2:0] code, input int len);
        seg_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_run: got code %0d for %0d cycles, expected none at %0t", code, len, $time);
        end else begin
            e = exp_q.pop_front();
            check("run_code", code, e.code);
            check("run_len", len, e.len);
        end
    endtask

    // Monitor: every completed non-idle selector run is matched against the queue.
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_sel = 3'b000;
            run_len  = 0;
        end else begin
            check("ocupado_vs_selector", ocupado, selector != 3'b000);
            check("selector_not_110", selector == 3'b110, 0);
            if (selector != prev_sel) begin
                if (prev_sel != 3'b000) finish_run(prev_sel, run_len);
                run_len  = 1;
                prev_sel = selector;
            end else run_len++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic [4:0] m);
        {b_in, b_ar, b_ab, b_iz, b_de} = m;
    endtask

    // Mask order {inicio, arriba, abajo, izquierda, derecha}; model works per press, not per cycle.
    task automatic press(input logic [4:0] m, input int hold, input bit gano_mid);
        logic [4:0] me;
        logic [2:0] code;
        me = (hold >= DEB + 3) ? m : 5'b0;
        if (me[4]) begin
            exp_q.push_back('{code: 3'b001, len: HOLD});
            movs = 0;
        end else if (!bloqueado && !gano && !perdio && |me[3:0]) begin
            code = me[3] ? 3'b011 : me[2] ? 3'b100 : me[1] ? 3'b101 : 3'b010;
            exp_q.push_back('{code: code, len: HOLD});
            exp_q.push_back('{code: 3'b111, len: HOLD});
            if (movs < 65535) movs++;
        end
        set_btn(m);
        if (gano_mid) begin
            cycles(21);
            gano = 1'b1;
            cycles(hold - 21);
        end else cycles(hold);
        set_btn(5'b0);
        cycles(40);
        bloqueado = me[4] ? (gano | perdio) : (bloqueado | gano | perdio);
`ifdef SECUENCIADOR_CONTADOR_EN
        check("cuenta_movs", int'(cuenta_movs), movs);
`endif
    endtask

    initial begin
        bit found;
        logic [4:0] m;
        cycles(3);
        check("reset_selector", selector, 0);
        check("reset_ocupado", ocupado, 0);
        rst_n = 1'b1;
        mon_en = 1;
        cycles(30);
        press(5'b01000, 20, 0);
        press(5'b00001, 5, 0);
        press(5'b00110, 25, 0);
        press(5'b00001, 30, 1);
        gano = 1'b0;
        press(5'b01000, 25, 0);
        perdio = 1'b1;
        press(5'b01000, 25, 0);
        press(5'b10000, 25, 0);
        perdio = 1'b0;
        press(5'b10000, 25, 0);
        press(5'b00010, 25, 0);
        mon_en = 0;
        set_btn(5'b01000);
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            if (selector == 3'b011) found = 1;
        end
        check("wait_mover_before_reset", found, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_selector", selector, 0);
        check("abort_ocupado", ocupado, 0);
        cycles(3);
        rst_n = 1'b1;
        bloqueado = 0;
        movs = 0;
        mon_en = 1;
        cycles(40);
        set_btn(5'b0);
        cycles(40);
        press(5'b01000, 25, 0);
        for (int n = 0; n < 25; n++) begin
            m = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) m[4] = 1'b0;
            gano   = ($urandom_range(0, 7) == 0);
            perdio = ($urandom_range(0, 7) == 0);
            press(m, 20 + $urandom_range(0, 20), 0);
        end
        gano = 1'b0;
        perdio = 1'b0;
        press(5'b10000, 25, 0);
        press(5'b00100, 25, 0);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/secuenciador_movimiento.md
SECUENCIADOR_MOVIMIENTO -- requirements
Module: secuenciador_movimiento

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive stable-input cycles required to accept a button level.
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, meaning cycles each non-idle selector code is held.
REQ-003 SHALL have port clk, input, 1, meaning single system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have ports btn_arriba, btn_abajo, btn_izquierda, btn_derecha, btn_inicio, each input, 1, meaning raw asynchronous active-high push buttons.
REQ-006 SHALL have ports gano and perdio, each input, 1, meaning win and loss flags from the downstream movement block.
REQ-007 SHALL have port selector, output, 3, meaning the command code driving the downstream movement block.
REQ-008 SHALL have port ocupado, output, 1, meaning a command sequence is in progress.

Function
REQ-009 SHALL use selector codes 000 reposo, 001 inicio, 010 derecha, 011 arriba, 100 abajo, 101 izquierda, 111 generar; 110 SHALL never be driven.
REQ-010 SHALL pass every button through a 2-flop synchronizer and then a debouncer; only debounced rising edges are commands.
REQ-011 SHALL implement states REPOSO, INICIO, MOVER, GENERAR, SOLTAR, BLOQUEO.
REQ-012 REPOSO: selector=000, ocupado=0; a debounced inicio edge -> INICIO; a direction edge with gano=0 and perdio=0 -> MOVER; gano or perdio =1 -> BLOQUEO.
REQ-013 Simultaneous edges in one cycle SHALL resolve by priority inicio > arriba > abajo > izquierda > derecha; lower-priority edges are discarded.
REQ-014 INICIO SHALL drive 001 for exactly HOLD_CYCLES cycles, then -> SOLTAR.
REQ-015 MOVER SHALL drive the latched direction code for exactly HOLD_CYCLES cycles, then -> GENERAR.
REQ-016 GENERAR SHALL drive 111 for exactly HOLD_CYCLES cycles, then -> SOLTAR.
REQ-017 SOLTAR SHALL drive 000 and wait until all debounced buttons are low, then -> REPOSO (or BLOQUEO if gano or perdio).
REQ-018 BLOQUEO SHALL drive 000, ignore direction buttons, and leave only on a debounced inicio edge -> INICIO.
REQ-019 ocupado SHALL be 1 in INICIO, MOVER, GENERAR; 0 otherwise.
REQ-020 Latency from debounced edge to first non-idle selector cycle SHALL be exactly 1 clock.
REQ-021 Button edges arriving while ocupado=1 or in SOLTAR SHALL be discarded, not queued.
REQ-022 gano/perdio asserting during MOVER or GENERAR SHALL NOT abort the sequence; it is honoured at SOLTAR.
REQ-023 Hold counter SHALL be ceil(log2(HOLD_CYCLES+1)) bits, reset to 0 on every state entry.

Reset
REQ-024 rst_n low SHALL immediately force state REPOSO, selector=000, ocupado=0, all counters and synchronizer/debouncer flops to 0.
REQ-025 Reset asserted mid-sequence SHALL abort it with no further non-idle codes; after release, held buttons SHALL NOT produce a command until released and pressed again.

Configuration
REQ-026 With SECUENCIADOR_CONTADOR_EN defined, SHALL add output cuenta_movs, 16 bits, counting completed MOVER->GENERAR sequences, saturating at 16'hFFFF, cleared by reset and on INICIO entry.
REQ-027 Without SECUENCIADOR_CONTADOR_EN, port cuenta_movs and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-028 Selector codes and the state enum SHALL live in shared package movimiento_pkg, also used by control_movimiento.
REQ-029 Synchronizer plus debouncer SHALL be sub-module antirrebote (parameter DEBOUNCE_CYCLES), instantiated once per button.

Verification
REQ-030 Reset, btn_arriba pulsed 20 cycles -> selector 011 for 4 cycles, then 111 for 4, then 000; ocupado high 8 cycles.
REQ-031 btn_derecha glitch of 5 cycles (< DEBOUNCE_CYCLES) -> selector stays 000.
REQ-032 btn_abajo and btn_izquierda rising same cycle -> only 100 then 111 emitted.
REQ-033 perdio=1 then btn_arriba press -> selector stays 000; btn_inicio press -> 001 for 4 cycles.
REQ-034 rst_n low during MOVER cycle 2 -> selector 000 same cycle; button still held after release -> no command.
REQ-035 With SECUENCIADOR_CONTADOR_EN, three direction presses -> cuenta_movs=3; inicio press -> 0.
